// File: rtl/ime_min_sel_pkg.sv
// ---------------------------------------------------------------------------
// ime_min_sel_pkg
// Purpose : shared defaults, window state type and compare-tree geometry
//           helpers for the IME minimum-cost selector.
// Contents: parameter defaults (PE count, cost width, mvd width), window FSM
//           state enum, per-level node count / flat-array offset functions.
// ---------------------------------------------------------------------------
package ime_min_sel_pkg;

    // Encoder-wide defaults for the IME datapath.
    localparam int unsigned PE_NUM_DEF     = 8;
    localparam int unsigned SAD4X4_LEN_DEF = 13;
    localparam int unsigned IMVD_LEN_DEF   = 8;

    // Search-window framing state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } win_state_e;

    // Number of nodes present at tree level lvl (level 0 = the PE lanes).
    // An odd node count rounds up: the unpaired node passes through.
    function automatic int unsigned lvl_nodes(input int unsigned n,
                                              input int unsigned lvl);
        int unsigned span;
        span = 32'd1 << lvl;
        return (n + span - 32'd1) >> lvl;
    endfunction

    // Offset of the first node of level lvl in the flattened node array.
    function automatic int unsigned lvl_off(input int unsigned n,
                                            input int unsigned lvl);
        int unsigned acc;
        acc = 32'd0;
        for (int unsigned j = 0; j < lvl; j++) begin
            acc = acc + lvl_nodes(n, j);
        end
        return acc;
    endfunction

endpackage : ime_min_sel_pkg

// File: rtl/ime_min2.sv
// ---------------------------------------------------------------------------
// ime_min2
// Purpose : combinational 2-input cell of the minimum-cost compare tree.
//           Carries {valid, cost, x}. Input a is always the lower lane index.
// Ports   : a_v_i/a_cost_i/a_x_i  lower-index candidate
//           b_v_i/b_cost_i/b_x_i  higher-index candidate
//           y_v_o/y_cost_o/y_x_o  winning candidate (combinational)
// ---------------------------------------------------------------------------
module ime_min2
    import ime_min_sel_pkg::*;
#(
    parameter int unsigned COST_LEN = SAD4X4_LEN_DEF,
    parameter int unsigned IMVD_LEN = IMVD_LEN_DEF
) (
    input  logic                a_v_i,
    input  logic [COST_LEN-1:0] a_cost_i,
    input  logic [IMVD_LEN-1:0] a_x_i,
    input  logic                b_v_i,
    input  logic [COST_LEN-1:0] b_cost_i,
    input  logic [IMVD_LEN-1:0] b_x_i,
    output logic                y_v_o,
    output logic [COST_LEN-1:0] y_cost_o,
    output logic [IMVD_LEN-1:0] y_x_o
);

    logic b_win;

    // b wins only when a is absent or b is strictly cheaper; ties stay with a.
    assign b_win    = b_v_i & (~a_v_i | (b_cost_i < a_cost_i));

    assign y_v_o    = a_v_i | b_v_i;
    assign y_cost_o = b_win ? b_cost_i : a_cost_i;
    assign y_x_o    = b_win ? b_x_i    : a_x_i;

endmodule : ime_min2

// File: rtl/ime_min_sel.sv
// ---------------------------------------------------------------------------
// ime_min_sel
// Purpose : pipelined minimum-cost selector for integer motion estimation.
//           Stage 0 reduces one beat of PE costs with a balanced compare
//           tree, stage 1 registers the beat winner, stage 2 accumulates the
//           best candidate over a start/last framed search window.
// Ports   : clk, rst          clock, synchronous active-high reset
//           start_i           window start (reinitialises accumulator)
//           cost_v_i, last_i  beat valid, final beat of window
//           pe_en_i           per-lane enable
//           cost_i            packed lane costs, lane k at [k*COST_LEN +: COST_LEN]
//           mvd_x_i, mvd_y_i  mvd of lane 0 (lane k x = mvd_x_i + k)
//           best_cost_o       running/final best cost
//           best_mvd_x_o/_y_o mvd of the best candidate
//           best_vld_o        an enabled candidate was accepted this window
//           done_o            one-cycle pulse, window result final
//           busy_o            window in progress
// ---------------------------------------------------------------------------
module ime_min_sel
    import ime_min_sel_pkg::*;
#(
    parameter int unsigned PE_NUM   = PE_NUM_DEF,
    parameter int unsigned COST_LEN = SAD4X4_LEN_DEF,
    parameter int unsigned IMVD_LEN = IMVD_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       cost_v_i,
    input  logic                       last_i,
    input  logic [PE_NUM-1:0]          pe_en_i,
    input  logic [PE_NUM*COST_LEN-1:0] cost_i,
    input  logic [IMVD_LEN-1:0]        mvd_x_i,
    input  logic [IMVD_LEN-1:0]        mvd_y_i,
    output logic [COST_LEN-1:0]        best_cost_o,
    output logic [IMVD_LEN-1:0]        best_mvd_x_o,
    output logic [IMVD_LEN-1:0]        best_mvd_y_o,
    output logic                       best_vld_o,
    output logic                       done_o,
    output logic                       busy_o
);

    localparam int unsigned LVLS   = $clog2(PE_NUM);
    // Every level lives in one flat array; the root is the last node.
    localparam int unsigned N_NODE = lvl_off(PE_NUM, LVLS) + 32'd1;
    localparam int unsigned ROOT   = N_NODE - 32'd1;

    // ------------------------------------------------------------------
    // Stage 0: compare tree
    // ------------------------------------------------------------------
    logic                nd_v    [N_NODE];
    logic [COST_LEN-1:0] nd_cost [N_NODE];
    logic [IMVD_LEN-1:0] nd_x    [N_NODE];

    // Leaves: lane candidates, x wraps modulo 2^IMVD_LEN.
    for (genvar k = 0; k < PE_NUM; k++) begin : g_leaf
        assign nd_v[k]    = cost_v_i & pe_en_i[k];
        assign nd_cost[k] = cost_i[k*COST_LEN +: COST_LEN];
        assign nd_x[k]    = mvd_x_i + IMVD_LEN'(k);
    end

    // Level l pairs nodes (2i, 2i+1) into node i of level l+1.
    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        localparam int unsigned N_IN  = lvl_nodes(PE_NUM, l);
        localparam int unsigned N_OUT = lvl_nodes(PE_NUM, l + 1);
        localparam int unsigned O_IN  = lvl_off(PE_NUM, l);
        localparam int unsigned O_OUT = lvl_off(PE_NUM, l + 1);

        for (genvar i = 0; i < N_OUT; i++) begin : g_node
            if (2*i + 1 < N_IN) begin : g_cell
                ime_min2 #(
                    .COST_LEN (COST_LEN),
                    .IMVD_LEN (IMVD_LEN)
                ) u_min2 (
                    .a_v_i    (nd_v   [O_IN + 2*i]),
                    .a_cost_i (nd_cost[O_IN + 2*i]),
                    .a_x_i    (nd_x   [O_IN + 2*i]),
                    .b_v_i    (nd_v   [O_IN + 2*i + 1]),
                    .b_cost_i (nd_cost[O_IN + 2*i + 1]),
                    .b_x_i    (nd_x   [O_IN + 2*i + 1]),
                    .y_v_o    (nd_v   [O_OUT + i]),
                    .y_cost_o (nd_cost[O_OUT + i]),
                    .y_x_o    (nd_x   [O_OUT + i])
                );
            end else begin : g_pass
                // Unpaired node carries through unchanged.
                assign nd_v   [O_OUT + i] = nd_v   [O_IN + 2*i];
                assign nd_cost[O_OUT + i] = nd_cost[O_IN + 2*i];
                assign nd_x   [O_OUT + i] = nd_x   [O_IN + 2*i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: beat result register
    // ------------------------------------------------------------------
    logic                s1_v_d,    s1_v_q;
    logic                s1_last_d, s1_last_q;
    logic [COST_LEN-1:0] s1_cost_d, s1_cost_q;
    logic [IMVD_LEN-1:0] s1_x_d,    s1_x_q;
    logic [IMVD_LEN-1:0] s1_y_d,    s1_y_q;

    // Loaded every cycle; a start simply overwrites the previous window's beat.
    assign s1_v_d    = nd_v[ROOT];
    assign s1_last_d = cost_v_i & last_i;
    assign s1_cost_d = nd_cost[ROOT];
    assign s1_x_d    = nd_x[ROOT];
    assign s1_y_d    = mvd_y_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_cost_q <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            s1_cost_q <= s1_cost_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: window accumulator and framing FSM
    // ------------------------------------------------------------------
    win_state_e          state_d,     state_q;
    logic [COST_LEN-1:0] best_cost_d, best_cost_q;
    logic [IMVD_LEN-1:0] best_x_d,    best_x_q;
    logic [IMVD_LEN-1:0] best_y_d,    best_y_q;
    logic                best_vld_d,  best_vld_q;
    logic                done_d,      done_q;

    // Next-state: start discards stage 1 and reinitialises; otherwise merge.
    always_comb begin
        state_d     = state_q;
        best_cost_d = best_cost_q;
        best_x_d    = best_x_q;
        best_y_d    = best_y_q;
        best_vld_d  = best_vld_q;
        done_d      = 1'b0;

        if (start_i) begin
            state_d     = ST_BUSY;
            best_cost_d = '1;
            best_x_d    = '0;
            best_y_d    = '0;
            best_vld_d  = 1'b0;
        end else begin
            // Strict compare: equal cost keeps the earlier beat, and an
            // all-ones cost can never displace the initial value.
            if (s1_v_q && (s1_cost_q < best_cost_q)) begin
                best_cost_d = s1_cost_q;
                best_x_d    = s1_x_q;
                best_y_d    = s1_y_q;
                best_vld_d  = 1'b1;
            end
            if (s1_last_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            best_cost_q <= '1;
            best_x_q    <= '0;
            best_y_q    <= '0;
            best_vld_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_cost_q <= best_cost_d;
            best_x_q    <= best_x_d;
            best_y_q    <= best_y_d;
            best_vld_q  <= best_vld_d;
            done_q      <= done_d;
        end
    end

    assign best_cost_o  = best_cost_q;
    assign best_mvd_x_o = best_x_q;
    assign best_mvd_y_o = best_y_q;
    assign best_vld_o   = best_vld_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q == ST_BUSY);

endmodule : ime_min_sel
